// File: rtl/m_axis_kernel_serializer_pkg.sv
// Shared widths, pixel/kernel types and read-FSM states for the 12k remapper output path.
// Pure declarations, no logic.
// Imported by the ping-pong bank and the stream serializer.
package remapper_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int IMAGE_KERNEL_12K = 64;
    localparam int LINE_KERNELS     = 192;

    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [0:IMAGE_KERNEL_12K-1] kernel_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/kernel_pingpong_bank.sv
// Two kernel registers with odd/sof tags; read side selects one pixel, reversed for odd kernels.
// Write lands on the clock edge; read is combinational from the stored banks.
// No flow control here: the caller guarantees a bank is never written while being read.
module kernel_pingpong_bank #(
    parameter int DW = 8,
    parameter int K  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_ptr,
    input  logic [0:K-1][DW-1:0]    wr_kernel,
    input  logic                    wr_odd,
    input  logic                    wr_sof,
    input  logic                    rd_ptr,
    input  logic [$clog2(K)-1:0]    rd_idx,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_sof
);
    import remapper_pkg::*;

    logic [0:K-1][DW-1:0]  kern [2];
    logic [1:0]            odd_tag;
    logic [1:0]            sof_tag;
    logic [$clog2(K)-1:0]  pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kern[0] <= '0;
            kern[1] <= '0;
            odd_tag <= '0;
            sof_tag <= '0;
        end else if (wr_en) begin
            kern[wr_ptr]    <= wr_kernel;
            odd_tag[wr_ptr] <= wr_odd;
            sof_tag[wr_ptr] <= wr_sof;
        end
    end

    // K is a power of two, so K-1-idx is simply the bitwise complement.
    assign pos     = odd_tag[rd_ptr] ? ~rd_idx : rd_idx;
    assign rd_data = kern[rd_ptr][pos];
    assign rd_sof  = sof_tag[rd_ptr];

endmodule

// File: rtl/m_axis_kernel_serializer.sv
// Captures parallel kernels into a ping-pong buffer and streams them pixel by pixel on AXI4-Stream.
// First beat is valid the cycle after the capture strobe; one beat per cycle while tready is high.
// Stalls hold the beat; a strobe with both banks full and no freeing handshake is dropped (sticky o_overflow).
module m_axis_kernel_serializer #(
    parameter int DATA_WIDTH       = remapper_pkg::DATA_WIDTH,
    parameter int IMAGE_KERNEL_12K = remapper_pkg::IMAGE_KERNEL_12K,
    parameter int LINE_KERNELS     = remapper_pkg::LINE_KERNELS
) (
    input  logic                                          i_clk,
    input  logic                                          i_areset,
    input  logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0]   i_image_kernel,
    input  logic                                          i_kernel_is_ready,
    input  logic                                          i_kernel_is_odd,
    input  logic                                          i_frame_start,
    output logic [DATA_WIDTH-1:0]                         m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tuser,
    output logic                                          m_axis_tlast,
    output logic                                          o_overflow,
    output logic                                          o_busy
);
    import remapper_pkg::*;

    localparam int K  = IMAGE_KERNEL_12K;
    localparam int IW = $clog2(K);
    localparam int LW = $clog2(LINE_KERNELS);

    rd_state_t          state;
    logic               tvalid_q;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fill;
    logic [1:0]         fill_next;
    logic [IW-1:0]      idx;
    logic [LW-1:0]      line_cnt;
    logic [LW-1:0]      cur_line;
    logic               pending_sof;
    logic               overflow_q;
    logic               hs;
    logic               final_hs;
    logic               accept;
    logic [DATA_WIDTH-1:0] bank_data;
    logic               bank_sof;

    kernel_pingpong_bank #(
        .DW (DATA_WIDTH),
        .K  (K)
    ) u_bank (
        .clk       (i_clk),
        .rst       (i_areset),
        .wr_en     (accept),
        .wr_ptr    (wr_ptr),
        .wr_kernel (i_image_kernel),
        .wr_odd    (i_kernel_is_odd),
        .wr_sof    (pending_sof | i_frame_start),
        .rd_ptr    (rd_ptr),
        .rd_idx    (idx),
        .rd_data   (bank_data),
        .rd_sof    (bank_sof)
    );

    assign hs        = tvalid_q & m_axis_tready;
    assign final_hs  = hs & (idx == IW'(K - 1));
    // A full buffer still accepts when the final beat frees the read bank in the same cycle.
    assign accept    = i_kernel_is_ready & ((fill != 2'd2) | final_hs);
    assign fill_next = fill + {1'b0, accept} - {1'b0, final_hs};
    // A sof-tagged bank behaves as if the line counter had been reset when it started.
    assign cur_line  = bank_sof ? '0 : line_cnt;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state       <= IDLE;
            tvalid_q    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fill        <= 2'd0;
            idx         <= '0;
            line_cnt    <= '0;
            pending_sof <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr ^ accept;
            fill   <= fill_next;
            if (i_kernel_is_ready && !accept)
                overflow_q <= 1'b1;
            if (accept)
                pending_sof <= 1'b0;
            else if (i_frame_start)
                pending_sof <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= STREAM;
                        tvalid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (hs)
                        idx <= idx + IW'(1);
                    if (final_hs) begin
                        rd_ptr   <= ~rd_ptr;
                        line_cnt <= (cur_line == LW'(LINE_KERNELS - 1)) ? '0 : cur_line + LW'(1);
                        if (fill_next == 2'd0) begin
                            state    <= IDLE;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? bank_data : '0;
    assign m_axis_tuser  = tvalid_q & bank_sof & (idx == '0);
    assign m_axis_tlast  = tvalid_q & (idx == IW'(K - 1)) & (cur_line == LW'(LINE_KERNELS - 1));
    assign o_overflow    = overflow_q;
    assign o_busy        = (fill != 2'd0);

endmodule

// File: tb/tb_m_axis_kernel_serializer.sv
// Bench for m_axis_kernel_serializer: random kernels and tready against a beat-queue reference model.
module tb_m_axis_kernel_serializer;

    localparam int DW = 8;
    localparam int K  = 64;
    localparam int LK = 192;

    typedef logic [0:K-1][DW-1:0] kern_t;
    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    kern_t         kin;
    logic          stb;
    logic          odd;
    logic          fs;
    logic          rdy;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tuser;
    logic          tlast;
    logic          ovf;
    logic          busy;

    int total = 0;
    int bad   = 0;

    beat_t q[$];
    bit    m_pend;
    bit    m_ovf;
    int    m_kpos;
    kern_t zero_k;

    always #5 clk = ~clk;

    m_axis_kernel_serializer #(
        .DATA_WIDTH       (DW),
        .IMAGE_KERNEL_12K (K),
        .LINE_KERNELS     (LK)
    ) dut (
        .i_clk             (clk),
        .i_areset          (rst),
        .i_image_kernel    (kin),
        .i_kernel_is_ready (stb),
        .i_kernel_is_odd   (odd),
        .i_frame_start     (fs),
        .m_axis_tdata      (tdata),
        .m_axis_tvalid     (tvalid),
        .m_axis_tready     (rdy),
        .m_axis_tuser      (tuser),
        .m_axis_tlast      (tlast),
        .o_overflow        (ovf),
        .o_busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b2w(input bit b);
        return b ? 32'd1 : 32'd0;
    endfunction

    function automatic int kernels_held();
        return (q.size() + K - 1) / K;
    endfunction

    function automatic kern_t ramp_kern();
        kern_t k;
        for (int i = 0; i < K; i++) k[i] = DW'(i);
        return k;
    endfunction

    function automatic kern_t rnd_kern();
        kern_t k;
        for (int i = 0; i < K; i++) k[i] = DW'($urandom);
        return k;
    endfunction

    task automatic check_outputs();
        chk("tvalid", 32'(tvalid), b2w(q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata", 32'(tdata), 32'(q[0].data));
            chk("tuser", 32'(tuser), 32'(q[0].user));
            chk("tlast", 32'(tlast), 32'(q[0].last));
        end
        chk("overflow", 32'(ovf), b2w(m_ovf));
        chk("busy", 32'(busy), b2w(q.size() > 0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        chk({tag, "_tdata"}, 32'(tdata), 32'd0);
        chk({tag, "_tuser"}, 32'(tuser), 32'd0);
        chk({tag, "_tlast"}, 32'(tlast), 32'd0);
        chk({tag, "_overflow"}, 32'(ovf), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One cycle: check what is on the outputs now, drive new inputs, then advance the model past the next edge.
    task automatic step(input logic s, input logic o, input logic f, input logic r, input kern_t kd);
        bit    hs;
        bit    fin;
        bit    acc;
        bit    sof;
        beat_t bt;
        @(negedge clk);
        check_outputs();
        stb = s;
        odd = o;
        fs  = f;
        rdy = r;
        kin = kd;
        hs  = (q.size() > 0) && r;
        fin = hs && (q.size() % K == 1);
        acc = s && (kernels_held() < 2 || fin);
        if (s && !acc) m_ovf = 1'b1;
        if (hs) void'(q.pop_front());
        if (acc) begin
            sof = m_pend | f;
            if (sof) m_kpos = 0;
            for (int b = 0; b < K; b++) begin
                bt.data = o ? kd[K-1-b] : kd[b];
                bt.user = sof && (b == 0);
                bt.last = (b == K - 1) && (m_kpos == LK - 1);
                q.push_back(bt);
            end
            m_kpos = (m_kpos == LK - 1) ? 0 : m_kpos + 1;
            m_pend = 1'b0;
        end else if (f) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, zero_k);
    endtask

    initial begin
        int sent;
        bit s;
        zero_k = '0;
        rst = 1'b1;
        kin = '0;
        stb = 1'b0;
        odd = 1'b0;
        fs  = 1'b0;
        rdy = 1'b0;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_kpos = 0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Even ramp kernel tagged sof, then odd ramp kernel, tready high.
        step(1'b1, 1'b0, 1'b1, 1'b1, ramp_kern());
        idle(70, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, ramp_kern());
        idle(70, 1'b1);

        // Four random kernels under random backpressure.
        sent = 0;
        for (int c = 0; c < 3000 && (sent < 4 || q.size() > 0); c++) begin
            s = (sent < 4) && (kernels_held() < 2) && ($urandom_range(0, 3) == 0);
            step(s, 1'(($urandom_range(0, 1))), 1'b0, 1'(($urandom_range(0, 1))), rnd_kern());
            if (s) sent++;
        end
        idle(3, 1'b1);

        // Three strobes while stalled: third one is dropped.
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_kern());
        step(1'b1, 1'b1, 1'b0, 1'b0, rnd_kern());
        step(1'b1, 1'b0, 1'b0, 1'b0, rnd_kern());
        idle(5, 1'b0);
        idle(134, 1'b1);

        // A full line of back-to-back kernels after a lone frame-start pulse, plus one more.
        step(1'b0, 1'b0, 1'b1, 1'b1, zero_k);
        sent = 0;
        for (int c = 0; c < (LK + 1) * K + 300 && (sent < LK + 1 || q.size() > 0); c++) begin
            s = (sent < LK + 1) && (kernels_held() < 2);
            step(s, 1'b0, 1'b0, 1'b1, rnd_kern());
            if (s) sent++;
        end
        idle(3, 1'b1);

        // Reset in the middle of beat 30.
        step(1'b1, 1'b0, 1'b0, 1'b1, rnd_kern());
        for (int c = 0; c < 100 && q.size() > K - 30; c++) idle(1, 1'b1);
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        check_all_zero("midreset_hold");
        rst = 1'b0;
        q.delete();
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_kpos = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1, rnd_kern());
        idle(70, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
